imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/imem_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch controller.
package imem_pkg;

  localparam int WORD      = 32;
  localparam int BYTE      = 8;
  localparam int MEM_BYTES = 168;
  localparam int RESET_PC  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch buffer: DEPTH entries of {pc, instr}, head visible
// combinationally, flush empties it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop, wr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Next pointer/count; flush wins over any push or pop in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && (count_q != CW'(DEPTH));
    wr_en    = do_push && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state and storage; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequential prefetch into a small buffer,
// one outstanding memory read, redirect flush, and fault on a bad fetch address.
module imem_fetch_ctrl #(
  parameter int WORD      = imem_pkg::WORD,
  parameter int MEM_BYTES = imem_pkg::MEM_BYTES,
  parameter int DEPTH     = 2,
  parameter int RESET_PC  = imem_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [WORD-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [WORD-1:0] mem_rdata,
  output logic            if_valid,
  output logic [WORD-1:0] if_instr,
  output logic [WORD-1:0] if_pc,
  input  logic            if_ready,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            fault
);

  import imem_pkg::*;

  localparam int              STEP    = WORD / BYTE;
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [WORD-1:0] LAST_PC = WORD'(MEM_BYTES - STEP);

  state_e            state_q, state_d;
  logic [WORD-1:0]   fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [WORD-1:0]   mem_addr_q, mem_addr_d;
  logic              fault_q, fault_d;

  logic              push, pop, pc_legal;
  logic [CW-1:0]     count;
  logic [2*WORD-1:0] head;

  assign pc_legal = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q <= LAST_PC);
  assign pop      = if_valid && if_ready;

  fetch_fifo #(
    .WIDTH (2 * WORD),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({fetch_pc_q, mem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  // Next-state logic; redirect overrides pop and ack, and a request already
  // on the bus must still be completed (DRAIN) before a new one may start.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fault_d    = fault_q;
    push       = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      fault_d    = 1'b0;
      case (state_q)
        REQ, DRAIN: begin
          if (mem_ack) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (!pc_legal) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else if (count < CW'(DEPTH)) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end
        end
        REQ: begin
          if (mem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + WORD'(STEP);
            state_d    = IDLE;
            mem_req_d  = 1'b0;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
        default: begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      endcase
    end
  end

  // FSM state and registered bus/fault outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= WORD'(RESET_PC);
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign fault    = fault_q;
  assign if_valid = (count != '0);
  assign if_pc    = head[2*WORD-1:WORD];
  assign if_instr = head[WORD-1:0];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: expected pops are queued by the
// stimulus, a monitor checks every accepted head entry, and a memory model
// answers requests with a programmable latency.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;

  imem_fetch_ctrl #(
    .WORD(32), .MEM_BYTES(168), .DEPTH(2), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int wcnt  = 0;
  int addr_moves = 0;
  logic [31:0] cur_addr = '0;
  logic [31:0] req_log[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_in_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_in_q.push_back(word_at(pc));
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    exp_pc_q.delete(); exp_in_q.delete();
    tick(1);
    redirect = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (exp_pc_q.size() != 0 && n < bound) begin tick(1); n++; end
    check(name, 32'(exp_pc_q.size()), 32'd0);
    if_ready = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] a);
    int n = 0;
    while (!(mem_req && mem_addr == a) && n < 60) begin tick(1); n++; end
    check(name, 32'(mem_req && mem_addr == a), 32'd1);
  endtask

  function automatic logic [31:0] next_after(input logic [31:0] a);
    for (int i = req_log.size() - 2; i >= 0; i--)
      if (req_log[i] == a) return req_log[i + 1];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] last_req();
    if (req_log.size() == 0) return 32'hFFFF_FFFF;
    return req_log[req_log.size() - 1];
  endfunction

  // Memory model: counts cycles of a held request, acks after lat cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (mem_req) begin
      if (wcnt == 0) begin
        req_log.push_back(mem_addr);
        cur_addr = mem_addr;
      end else if (mem_addr != cur_addr) begin
        addr_moves++;
      end
      wcnt++;
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = word_at(mem_addr);
      end
    end
  end

  // Monitor: every accepted head entry must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready && !redirect) begin
      if (exp_pc_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_unexpected: got pc 0x%0h, no entry queued", if_pc);
      end else begin
        check("pop_pc", if_pc, exp_pc_q.pop_front());
        check("pop_instr", if_instr, exp_in_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base;

  initial begin
    rst_n = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_mem_addr", mem_addr,      32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr,      32'd0);
    check("rst_if_pc",    if_pc,         32'd0);
    check("rst_fault",    32'(fault),    32'd0);

    // Sequential fetch from RESET_PC with latency 1
    for (int a = 0; a < 32; a += 4) push_exp(a);
    @(posedge clk); #1;
    rst_n = 1'b1; if_ready = 1'b1;
    wait_drain("seq_drain", 200);

    // Decode stalled for 10 cycles: buffer holds exactly 0x20, 0x24
    tick(10);
    check("full_mem_req", 32'(mem_req),  32'd0);
    check("full_valid",   32'(if_valid), 32'd1);
    check("full_head_pc", if_pc,         32'h20);
    check("full_head_in", if_instr,      32'hC0DE0020);
    check("full_last_req", last_req(),   32'h24);
    for (int a = 32'h20; a < 32'h40; a += 4) push_exp(a);
    if_ready = 1'b1;
    wait_drain("stall_drain", 200);

    // Redirect during a slow request to 0x08 -> DRAIN
    tick(8);
    lat = 3;
    do_redirect(32'h08);
    wait_req("drain_req_seen", 32'h08);
    redirect = 1'b1; redirect_pc = 32'h20;
    tick(1);
    redirect = 1'b0;
    check("drain_req1",  32'(mem_req),  32'd1);
    check("drain_addr1", mem_addr,      32'h08);
    check("drain_flush", 32'(if_valid), 32'd0);
    tick(1);
    check("drain_req2",  32'(mem_req),  32'd1);
    check("drain_addr2", mem_addr,      32'h08);
    for (int a = 32'h20; a < 32'h30; a += 4) push_exp(a);
    if_ready = 1'b1;
    wait_drain("drain_stream", 300);
    check("drain_next_req", next_after(32'h08), 32'h20);

    // Redirect coincident with mem_ack and a pop
    tick(20);
    do_redirect(32'h50);
    wait_req("coin_req_seen", 32'h54);
    tick(2);
    check("coin_pre_valid", 32'(if_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h10; if_ready = 1'b1;
    tick(1);
    redirect = 1'b0; if_ready = 1'b0;
    check("coin_empty",   32'(if_valid), 32'd0);
    check("coin_mem_req", 32'(mem_req),  32'd0);
    for (int a = 32'h10; a < 32'h20; a += 4) push_exp(a);
    if_ready = 1'b1;
    wait_drain("coin_stream", 300);
    check("coin_next_req", next_after(32'h54), 32'h10);

    // Fetch runs off the end of memory -> fault, buffered words still pop
    tick(20);
    lat = 1;
    do_redirect(32'hA0);
    tick(10);
    check("flt_fault",   32'(fault),    32'd1);
    check("flt_mem_req", 32'(mem_req),  32'd0);
    check("flt_valid",   32'(if_valid), 32'd1);
    check("flt_head_pc", if_pc,         32'hA0);
    push_exp(32'hA0); push_exp(32'hA4);
    if_ready = 1'b1;
    wait_drain("flt_drain", 100);
    tick(3);
    check("flt_fault_hold", 32'(fault),   32'd1);
    check("flt_no_req",     32'(mem_req), 32'd0);
    check("flt_last_req",   last_req(),   32'hA4);
    do_redirect(32'h06);
    check("mis_cleared",  32'(fault),   32'd0);
    tick(2);
    check("mis_fault",    32'(fault),   32'd1);
    check("mis_no_req",   32'(mem_req), 32'd0);
    check("mis_last_req", last_req(),   32'hA4);
    if_ready = 1'b1;
    do_redirect(32'h04);
    push_exp(32'h04); push_exp(32'h08);
    wait_drain("resume_drain", 100);
    check("resume_fault", 32'(fault), 32'd0);

    // Reset while a request is on the bus
    lat = 3;
    do_redirect(32'h40);
    wait_req("rst_req_seen", 32'h40);
    rst_n = 1'b0;
    #1;
    check("rr_mem_req",  32'(mem_req),  32'd0);
    check("rr_mem_addr", mem_addr,      32'd0);
    check("rr_if_valid", 32'(if_valid), 32'd0);
    check("rr_if_instr", if_instr,      32'd0);
    check("rr_if_pc",    if_pc,         32'd0);
    check("rr_fault",    32'(fault),    32'd0);
    exp_pc_q.delete(); exp_in_q.delete();
    tick(2);
    base = req_log.size();
    lat = 1;
    push_exp(32'h00); push_exp(32'h04);
    rst_n = 1'b1; if_ready = 1'b1;
    wait_drain("rr_drain", 100);
    check("rr_first_req", (req_log.size() > base) ? req_log[base] : 32'hFFFF_FFFF, 32'h00);

    check("addr_stable", 32'(addr_moves), 32'd0);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
